ps2_kbd_ctrl: RTL

- Sequences the raw byte stream from ps2_interface (scancode + is_valid) into decoded key events.
- Strips the Set-2 prefix bytes 0xE0 (extended) and 0xF0 (break), then produces one event per key action.
- Queues events in a small FIFO so the CPU side can read them with a valid/read handshake.
- Sits between ps2_interface and the CPU memory-mapped keyboard register.

---
 rtl/ps2_kbd_ctrl_if.sv | 27 ++
 rtl/ps2_kbd_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl_if.sv
// Bundle between ps2_kbd_ctrl and its neighbours: the scancode byte stream
// in, and the CPU-side event FIFO read port, status flags and error pulse out.
interface ps2_kbd_ctrl_if #(
  parameter int AW = 3
);
  logic [7:0]  scancode;
  logic        scan_valid;
  logic        evt_rd;
  logic        ovf_clr;
  logic        evt_valid;
  logic [7:0]  evt_code;
  logic        evt_ext;
  logic        evt_break;
  logic [AW:0] evt_count;
  logic        overflow;
  logic        err_pulse;

  modport master (
    output scancode, scan_valid, evt_rd, ovf_clr,
    input  evt_valid, evt_code, evt_ext, evt_break, evt_count, overflow, err_pulse
  );

  modport slave (
    input  scancode, scan_valid, evt_rd, ovf_clr,
    output evt_valid, evt_code, evt_ext, evt_break, evt_count, overflow, err_pulse
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 Set-2 byte sequencer: strips E0/F0 prefixes into key events queued in a show-ahead FIFO.
// Optional prefix watchdog enabled by defining PS2_KBD_TIMEOUT_EN.
module ps2_kbd_ctrl #(
  parameter int DEPTH          = 8,
  parameter int AW             = 3,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic           clk,
  input logic           rst_n,
  ps2_kbd_ctrl_if.slave bus
);

  if (((1 << AW) != DEPTH) || (DEPTH < 2) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("ps2_kbd_ctrl: DEPTH must equal 2**AW (>=2) and TIMEOUT_CYCLES must be positive");
  end

  // Bit 0 of the state means "E0 seen", bit 1 means "F0 seen".
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRE_E0   = 2'd1;
  localparam logic [1:0] PRE_F0   = 2'd2;
  localparam logic [1:0] PRE_E0F0 = 2'd3;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  logic          scan_valid_q;
  logic          stb;
  logic [1:0]    state_q, state_d, state_eff;
  logic [AW:0]   wr_cnt_q, rd_cnt_q, count;
  evt_t          mem_q [DEPTH];
  evt_t          last_q, head, push_evt;
  logic          overflow_q, overflow_d;
  logic          err_q, err_d;
  logic          push_req, push, pop, drop, full, empty, is_err, timeout;

  assign stb = bus.scan_valid & ~scan_valid_q;

`ifdef PS2_KBD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign timeout = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n)                                   tmo_q <= '0;
    else if (stb || (state_q == IDLE) || timeout) tmo_q <= '0;
    else                                          tmo_q <= tmo_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every variable assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_eff = timeout ? IDLE : state_q;
    state_d   = state_eff;
    push_req  = 1'b0;
    is_err    = 1'b0;
    push_evt  = '{ext: state_eff[0], brk: state_eff[1], code: bus.scancode};
    if (stb) begin
      unique case (bus.scancode)
        8'hE0:        state_d = state_eff | PRE_E0;
        8'hF0:        state_d = state_eff | PRE_F0;
        8'h00, 8'hFF: begin state_d = IDLE; is_err = 1'b1; end
        default:      begin state_d = IDLE; push_req = 1'b1; end
      endcase
    end

    count      = wr_cnt_q - rd_cnt_q;
    empty      = (count == '0);
    full       = count[AW];
    pop        = bus.evt_rd & ~empty;
    push       = push_req & (~full | pop);
    drop       = push_req & full & ~pop;
    overflow_d = drop | (overflow_q & ~bus.ovf_clr);
    err_d      = is_err | timeout;
    head       = mem_q[rd_cnt_q[AW-1:0]];
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_valid_q <= 1'b0;
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      last_q       <= '0;
      overflow_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      scan_valid_q <= bus.scan_valid;
      state_q      <= state_d;
      overflow_q   <= overflow_d;
      err_q        <= err_d;
      if (push) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (pop) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        last_q   <= head;
      end
    end
  end

  // NOTE: the storage array is not reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_cnt_q[AW-1:0]] <= push_evt;
  end

  // When empty the outputs hold the most recently popped entry.
  assign bus.evt_valid = ~empty;
  assign bus.evt_code  = empty ? last_q.code : head.code;
  assign bus.evt_ext   = empty ? last_q.ext  : head.ext;
  assign bus.evt_break = empty ? last_q.brk  : head.brk;
  assign bus.evt_count = count;
  assign bus.overflow  = overflow_q;
  assign bus.err_pulse = err_q;

endmodule
